inst_fetch_unit: RTL
====================

INST_FETCH_UNIT -- requirements
Module: inst_fetch_unit

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, meaning PC and instruction-memory address width.
REQ-002 The block SHALL have parameter INSTR_W, default 8, meaning instruction width; legal only when ADDR_W > INSTR_W-2.
REQ-003 The block SHALL have parameter DEPTH, default 4, meaning prefetch queue entries; power of two, >=2.
REQ-004 The block SHALL have parameter RESET_PC, default 0, meaning PC value loaded by reset.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 The block SHALL have port imem_addr, output, ADDR_W bits: instruction-memory address, equal to the current PC.
REQ-008 The block SHALL have port imem_data, input, INSTR_W bits: instruction at imem_addr, combinational, valid in the same cycle.
REQ-009 The block SHALL have port redirect_valid, input, 1 bit: external PC redirect request (branch or exception).
REQ-010 The block SHALL have port redirect_pc, input, ADDR_W bits: redirect target, sampled when redirect_valid=1.
REQ-011 The block SHALL have port out_valid, output, 1 bit: queue head holds a valid instruction.
REQ-012 The block SHALL have port out_ready, input, 1 bit: decode accepts the head this cycle.
REQ-013 The block SHALL have port out_instr, output, INSTR_W bits: head instruction.
REQ-014 The block SHALL have port out_pc, output, ADDR_W bits: address the head instruction was fetched from.
REQ-015 The block SHALL have port q_count, output, clog2(DEPTH)+1 bits: current queue occupancy.

Function
REQ-016 The block SHALL compute pc_inc = (pc+1) mod 2^ADDR_W, wrapping from all-ones to 0.
REQ-017 The block SHALL treat imem_data[INSTR_W-1]=1 as a jump, with target = {pc_inc[ADDR_W-1:INSTR_W-2], imem_data[INSTR_W-3:0]}; defaults: pc_inc[7:6] concatenated with instr[5:0].
REQ-018 The block SHALL perform a fetch in a cycle when redirect_valid=0 and (q_count<DEPTH or a pop occurs that cycle).
REQ-019 On a fetch, the block SHALL push {pc, imem_data} into the queue and load pc with the jump target if a jump, else pc_inc.
REQ-020 With no fetch and no redirect, the block SHALL hold pc and issue no push.
REQ-021 The block SHALL pop the head when out_valid=1 and out_ready=1; out_valid SHALL equal (q_count!=0).
REQ-022 Simultaneous push and pop SHALL leave q_count unchanged, including at q_count=DEPTH (full) and q_count=1.
REQ-023 out_instr/out_pc SHALL be the queue head, registered storage; out_valid=0 when empty, with out_instr/out_pc don't-care.
REQ-024 A push into an empty queue SHALL make that entry visible on out_* the following cycle; fetch-to-output latency is one cycle.
REQ-025 On redirect_valid=1, the block SHALL load pc <= redirect_pc, discard all queue entries (q_count <= 0), perform no push and no pop that cycle, and ignore out_ready.
REQ-026 Queue read/write pointers SHALL wrap modulo DEPTH; overflow and underflow SHALL be impossible by construction.
REQ-027 The jump decode SHALL apply only to the instruction being fetched, never to queued entries.

Reset
REQ-028 When rst=1 at a rising edge, the block SHALL set pc <= RESET_PC, pointers <= 0, q_count <= 0, out_valid <= 0; rst SHALL override redirect_valid and out_ready.
REQ-029 Reset asserted mid-operation SHALL discard queued entries; the first fetch SHALL occur from RESET_PC in the first cycle with rst=0.

Verification
REQ-030 Defaults: rst, then out_ready=1, memory[i]=i for non-jumps (bit7=0) -> out_pc 0,1,2,... one per cycle from cycle 2; q_count steady at 1.
REQ-031 out_ready=0 for 10 cycles -> q_count saturates at 4, imem_addr holds at 4; out_ready=1 -> pcs 0,1,2,3,4 delivered without gap or duplicate.
REQ-032 At pc=0x45, instr=0x9A (jump) -> pc_inc=0x46, next pc=0x5A; delivered entry has out_pc=0x45, out_instr=0x9A.
REQ-033 Non-jump at pc=0xFF -> next pc=0x00; jump 0x83 at pc=0xFF -> target {00,000011}=0x03.
REQ-034 Queue at 3 entries, redirect_valid=1, redirect_pc=0x20, out_ready=1 -> next cycle q_count=0, out_valid=0, imem_addr=0x20; one cycle later out_pc=0x20.
REQ-035 rst=1 with queue full and redirect_valid=1 -> pc=RESET_PC, q_count=0; redirect ignored.

Source files
------------

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: sequential instruction fetch with a prefetch queue.
//   Each fetch pushes {pc, imem_data} into a DEPTH-entry circular queue.
//   The next PC is either pc+1 or, when the fetched instruction's top bit is set,
//   a page-relative jump target. A redirect flushes the queue and reloads the PC.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   imem_addr / imem_data    combinational instruction memory (addr = current pc)
//   redirect_valid/_pc       external PC redirect (branch/exception)
//   out_valid/ready/instr/pc head of queue, valid/ready handshake to decode
//   q_count                  queue occupancy, 0..DEPTH
module inst_fetch_unit #(
  parameter int ADDR_W   = 8,
  parameter int INSTR_W  = 8,
  parameter int DEPTH    = 4,
  parameter int RESET_PC = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic [ADDR_W-1:0]          imem_addr,
  input  logic [INSTR_W-1:0]         imem_data,
  input  logic                       redirect_valid,
  input  logic [ADDR_W-1:0]          redirect_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [INSTR_W-1:0]         out_instr,
  output logic [ADDR_W-1:0]          out_pc,
  output logic [$clog2(DEPTH):0]     q_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [PW-1:0]      wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [ADDR_W-1:0]  pcs_q [DEPTH];
  logic [INSTR_W-1:0] ins_q [DEPTH];

  logic              pop, fetch, jump;
  logic [ADDR_W-1:0] pc_inc, jmp_tgt;

  assign imem_addr = pc_q;
  assign out_valid = (cnt_q != '0);
  assign out_instr = ins_q[rptr_q];
  assign out_pc    = pcs_q[rptr_q];
  assign q_count   = cnt_q;

  // Jump target keeps the upper bits of pc+1 (the "page") and takes the low
  // INSTR_W-2 bits from the instruction being fetched.
  assign pc_inc  = pc_q + ADDR_W'(1);
  assign jump    = imem_data[INSTR_W-1];
  assign jmp_tgt = {pc_inc[ADDR_W-1:INSTR_W-2], imem_data[INSTR_W-3:0]};

  // A redirect suppresses both sides of the queue; a pop frees a slot in the
  // same cycle, so a full queue can still fetch while decode drains it.
  assign pop   = out_valid & out_ready & ~redirect_valid;
  assign fetch = ~redirect_valid & ((cnt_q < CW'(DEPTH)) | pop);

  always_comb begin
    pc_d   = pc_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (redirect_valid) begin
      pc_d   = redirect_pc;
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (fetch) begin
        pc_d   = jump ? jmp_tgt : pc_inc;
        wptr_d = wptr_q + PW'(1);
      end
      if (pop) rptr_d = rptr_q + PW'(1);
      case ({fetch, pop})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q   <= ADDR_W'(RESET_PC);
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      pc_q   <= pc_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Queue storage needs no reset: entries are only visible while counted.
  always_ff @(posedge clk) begin
    if (!rst && fetch) begin
      pcs_q[wptr_q] <= pc_q;
      ins_q[wptr_q] <= imem_data;
    end
  end
endmodule
